// File: rtl/pomo_pkg.sv
// pomo_pkg: shared types and helpers for the Pomodoro cycle timer.
//   state_e  : controller states IDLE/RUN/PAUSE/ALARM
//   phase_e  : Pomodoro phase WORK/SHORT/LONG (encoding 3 is never used)
//   to_bcd8  : binary 0..99 to two packed BCD digits, for duration constants
//   BCD_ZERO : two-digit BCD zero
package pomo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_WORK  = 2'd0,
    PH_SHORT = 2'd1,
    PH_LONG  = 2'd2
  } phase_e;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  function automatic logic [7:0] to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// bcd_mmss_down: mm:ss down-counter held entirely in BCD.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (resets to RST_MIN:00)
//   load_i      : load load_min_i:00 (wins over dec_i)
//   load_min_i  : minutes to load, two BCD digits
//   dec_i       : decrement by one second
//   min_o/sec_o : current minutes/seconds, two BCD digits each
//   zero_o      : this decrement lands on 00:00 (count is 00:01 and dec_i high)
module bcd_mmss_down
  import pomo_pkg::*;
#(
  parameter logic [7:0] RST_MIN = 8'h25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_min_i,
  input  logic       dec_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       zero_o
);

  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;

  // Two-digit BCD decrement with per-digit borrow; 00 wraps to 99.
  function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      r[7:4] = (v[7:4] != 4'd0) ? v[7:4] - 4'd1 : 4'd9;
    end
    return r;
  endfunction

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (load_i) begin
      min_d = load_min_i;
      sec_d = BCD_ZERO;
    end else if (dec_i) begin
      // Seconds tens digit only spans 0..5, so a borrow out of :00 reloads :59.
      if (sec_q == BCD_ZERO) begin
        sec_d = 8'h59;
        min_d = bcd_dec8(min_q);
      end else begin
        sec_d = bcd_dec8(sec_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= RST_MIN;
      sec_q <= BCD_ZERO;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  assign min_o  = min_q;
  assign sec_o  = sec_q;
  assign zero_o = dec_i && (min_q == BCD_ZERO) && (sec_q == 8'h01);

endmodule

// File: rtl/pomo_cycle_timer.sv
// pomo_cycle_timer: sequences Pomodoro cycles (work / short break / long break
// every CYCLES_PER_LONG works) with run, pause, skip and alarm handling.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_stop   : 1-cycle pulse, start / pause / resume / acknowledge alarm
//   skip         : 1-cycle pulse, abandon current phase (ignored in ALARM)
//   min_bcd      : minutes, two BCD digits
//   sec_bcd      : seconds, two BCD digits
//   blink_7sd    : 1 = blank display digits (blinks in PAUSE and ALARM)
//   phase        : 0 WORK, 1 SHORT, 2 LONG
//   cycle_cnt    : completed works since the last long break
//   alarm        : high while in ALARM
//   running      : high while in RUN
// Build option: define POMO_AUTO_ADVANCE_EN to start the next phase running
// straight out of ALARM instead of waiting in IDLE.
module pomo_cycle_timer
  import pomo_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned BLINK_HZ        = 2,
  parameter int unsigned WORK_MIN        = 25,
  parameter int unsigned SHORT_MIN       = 5,
  parameter int unsigned LONG_MIN        = 15,
  parameter int unsigned CYCLES_PER_LONG = 4,
  parameter int unsigned ALARM_SEC       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       skip,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       blink_7sd,
  output logic [1:0] phase,
  output logic [3:0] cycle_cnt,
  output logic       alarm,
  output logic       running
);

  localparam int unsigned PW   = $clog2(CLK_HZ);
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [7:0] WORK_BCD  = to_bcd8(WORK_MIN);
  localparam logic [7:0] SHORT_BCD = to_bcd8(SHORT_MIN);
  localparam logic [7:0] LONG_BCD  = to_bcd8(LONG_MIN);

`ifdef POMO_AUTO_ADVANCE_EN
  localparam state_e DONE_ST = ST_RUN;
`else
  localparam state_e DONE_ST = ST_IDLE;
`endif

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [3:0]      cycle_q, cycle_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            blink_q, blink_d;
  logic [7:0]      acnt_q, acnt_d;
  logic            alarm_q, running_q;

  logic            tick;
  logic            load;
  logic            zero;
  phase_e          nxt_phase;
  logic [3:0]      nxt_cycle_skip, nxt_cycle_done;
  logic [7:0]      nxt_dur;

  assign tick = ((state_q == ST_RUN) || (state_q == ST_ALARM)) &&
                (presc_q == PW'(CLK_HZ - 1));

  // Phase that follows the current one. Completion and skip agree on the
  // target phase; only completion counts the finished work.
  always_comb begin
    nxt_phase      = PH_WORK;
    nxt_cycle_skip = cycle_q;
    nxt_cycle_done = cycle_q;
    if (phase_q == PH_WORK) begin
      if (cycle_q == 4'(CYCLES_PER_LONG - 1)) begin
        nxt_phase      = PH_LONG;
        nxt_cycle_skip = 4'd0;
        nxt_cycle_done = 4'd0;
      end else begin
        nxt_phase      = PH_SHORT;
        nxt_cycle_done = cycle_q + 4'd1;
      end
    end
    case (nxt_phase)
      PH_SHORT: nxt_dur = SHORT_BCD;
      PH_LONG:  nxt_dur = LONG_BCD;
      default:  nxt_dur = WORK_BCD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cycle_d = cycle_q;
    acnt_d  = acnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (skip) begin
          phase_d = nxt_phase;
          cycle_d = nxt_cycle_skip;
          load    = 1'b1;
          state_d = ST_IDLE;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Reaching 00:00 outranks a pause on the same edge so the alarm is
        // never lost with the count parked at zero.
        if (skip) begin
          phase_d = nxt_phase;
          cycle_d = nxt_cycle_skip;
          load    = 1'b1;
          state_d = ST_IDLE;
        end else if (zero) begin
          acnt_d  = 8'd0;
          state_d = ST_ALARM;
        end else if (start_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (start_stop || (tick && (acnt_q == 8'(ALARM_SEC - 1)))) begin
          phase_d = nxt_phase;
          cycle_d = nxt_cycle_done;
          load    = 1'b1;
          state_d = DONE_ST;
        end else if (tick) begin
          acnt_d = acnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler: fresh second on any start from IDLE/ALARM, held through PAUSE.
  always_comb begin
    presc_d = presc_q;
    if ((state_d == ST_IDLE) ||
        (((state_q == ST_IDLE) || (state_q == ST_ALARM)) && (state_d == ST_RUN))) begin
      presc_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_ALARM)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // Blink divider: starts blanked on entry to PAUSE/ALARM, off elsewhere.
  always_comb begin
    blink_d = 1'b0;
    bcnt_d  = '0;
    if ((state_d == ST_PAUSE) || (state_d == ST_ALARM)) begin
      if (state_q != state_d) begin
        blink_d = 1'b1;
      end else if (bcnt_q == BW'(HALF - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_WORK;
      cycle_q   <= 4'd0;
      presc_q   <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      acnt_q    <= 8'd0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cycle_q   <= cycle_d;
      presc_q   <= presc_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      acnt_q    <= acnt_d;
      alarm_q   <= (state_d == ST_ALARM);
      running_q <= (state_d == ST_RUN);
    end
  end

  bcd_mmss_down #(
    .RST_MIN (WORK_BCD)
  ) u_mmss (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_min_i (nxt_dur),
    .dec_i      (tick && (state_q == ST_RUN)),
    .min_o      (min_bcd),
    .sec_o      (sec_bcd),
    .zero_o     (zero)
  );

  assign blink_7sd = blink_q;
  assign phase     = phase_q;
  assign cycle_cnt = cycle_q;
  assign alarm     = alarm_q;
  assign running   = running_q;

endmodule

// File: tb/tb_pomo_cycle_timer.sv
module tb_pomo_cycle_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_stop;
  logic       skip;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       blink_7sd;
  logic [1:0] phase;
  logic [3:0] cycle_cnt;
  logic       alarm;
  logic       running;

  int checks = 0;
  int failures = 0;

  pomo_cycle_timer #(
    .CLK_HZ          (4),
    .BLINK_HZ        (1),
    .WORK_MIN        (1),
    .SHORT_MIN       (1),
    .LONG_MIN        (2),
    .CYCLES_PER_LONG (2),
    .ALARM_SEC       (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .skip       (skip),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .blink_7sd  (blink_7sd),
    .phase      (phase),
    .cycle_cnt  (cycle_cnt),
    .alarm      (alarm),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; the pulse is captured by the next posedge and the
  // task returns on the negedge after it.
  task automatic pulse(input logic ss, input logic sk);
    start_stop = ss;
    skip       = sk;
    @(negedge clk);
    start_stop = 1'b0;
    skip       = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] m, input logic [7:0] s,
                         input logic [1:0] ph, input logic [3:0] cy, input logic bl,
                         input logic al, input logic rn);
    chk({tag, "_min"},   min_bcd, m);
    chk({tag, "_sec"},   sec_bcd, s);
    chk({tag, "_phase"}, {6'd0, phase}, {6'd0, ph});
    chk({tag, "_cycle"}, {4'd0, cycle_cnt}, {4'd0, cy});
    chk({tag, "_blink"}, {7'd0, blink_7sd}, {7'd0, bl});
    chk({tag, "_alarm"}, {7'd0, alarm}, {7'd0, al});
    chk({tag, "_run"},   {7'd0, running}, {7'd0, rn});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start_stop = 1'b0;
    skip       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("reset", 8'h01, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // First WORK: start, first second after 4 clocks, alarm at 240.
    pulse(1'b1, 1'b0);
    chk("start_run", {7'd0, running}, 8'd1);
    repeat (3) @(negedge clk);
    chk("w_e3_sec", sec_bcd, 8'h00);
    chk("w_e3_min", min_bcd, 8'h01);
    @(negedge clk);
    chk("w_e4_sec", sec_bcd, 8'h59);
    chk("w_e4_min", min_bcd, 8'h00);
    repeat (235) @(negedge clk);
    chk("w_e239_sec", sec_bcd, 8'h01);
    chk("w_e239_alarm", {7'd0, alarm}, 8'd0);
    @(negedge clk);
    chk_all("w_alarm", 8'h00, 8'h00, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    chk("w_alarm_e247", {7'd0, alarm}, 8'd1);
    @(negedge clk);
    chk_all("w_done", 8'h01, 8'h00, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);

    // SHORT break with a pause at 00:45.
    pulse(1'b1, 1'b0);
    repeat (60) @(negedge clk);
    chk("s_e60_sec", sec_bcd, 8'h45);
    pulse(1'b1, 1'b0);
    chk("pause_run", {7'd0, running}, 8'd0);
    chk("pause_blink0", {7'd0, blink_7sd}, 8'd1);
    @(negedge clk);
    chk("pause_blink1", {7'd0, blink_7sd}, 8'd1);
    @(negedge clk);
    chk("pause_blink2", {7'd0, blink_7sd}, 8'd0);
    repeat (2) @(negedge clk);
    chk("pause_blink4", {7'd0, blink_7sd}, 8'd1);
    repeat (96) @(negedge clk);
    chk("pause_hold_sec", sec_bcd, 8'h45);
    chk("pause_hold_min", min_bcd, 8'h00);
    pulse(1'b1, 1'b0);
    chk("resume_run", {7'd0, running}, 8'd1);
    chk("resume_blink", {7'd0, blink_7sd}, 8'd0);
    repeat (2) @(negedge clk);
    chk("resume_r2_sec", sec_bcd, 8'h45);
    @(negedge clk);
    chk("resume_r3_sec", sec_bcd, 8'h44);
    repeat (176) @(negedge clk);
    chk("s_alarm", {7'd0, alarm}, 8'd1);
    chk("s_alarm_sec", sec_bcd, 8'h00);
    repeat (8) @(negedge clk);
    chk_all("s_done", 8'h01, 8'h00, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Second WORK: alarm acknowledged early, long break follows.
    pulse(1'b1, 1'b0);
    repeat (240) @(negedge clk);
    chk("w2_alarm", {7'd0, alarm}, 8'd1);
    pulse(1'b1, 1'b0);
    chk_all("w2_ack", 8'h02, 8'h00, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);

    // Skip LONG from IDLE, then skip+start_stop together in RUN during WORK.
    pulse(1'b0, 1'b1);
    chk_all("skip_long", 8'h01, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("w3_sec", sec_bcd, 8'h58);
    pulse(1'b1, 1'b1);
    chk_all("skip_both", 8'h01, 8'h00, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN.
    pulse(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_sec", sec_bcd, 8'h59);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h01, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
